pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid.sv | 121 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline stage (head + skid) carrying wb/wreg/rd/alu fields.
// Optional build macro PIPE_STAGE_PERF_EN adds stall_cycles/bubble_cycles counters.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int WB_W   = 2,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_reg,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   in_wb,
    input  logic [REG_W-1:0]  in_wreg,
    input  logic [DATA_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_alu,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   out_wb,
    output logic [REG_W-1:0]  out_wreg,
    output logic [DATA_W-1:0] out_rd,
    output logic [DATA_W-1:0] out_alu,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       bubble_cycles
`endif
);

    logic              head_valid, skid_valid;
    logic [WB_W-1:0]   head_wb, skid_wb;
    logic [REG_W-1:0]  head_wreg, skid_wreg;
    logic [DATA_W-1:0] head_rd, skid_rd;
    logic [DATA_W-1:0] head_alu, skid_alu;
    logic              accept, do_release;

    // in_ready depends only on registered state and en_reg, never on out_ready
    assign in_ready   = en_reg & ~skid_valid & ~rst;
    assign accept     = in_valid & in_ready;
    assign do_release = head_valid & out_ready & en_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            head_wb    <= '0;
            head_wreg  <= '0;
            head_rd    <= '0;
            head_alu   <= '0;
            skid_wb    <= '0;
            skid_wreg  <= '0;
            skid_rd    <= '0;
            skid_alu   <= '0;
        end else if (en_reg) begin
            if (flush) begin
                head_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (do_release && skid_valid) begin
                head_wb    <= skid_wb;
                head_wreg  <= skid_wreg;
                head_rd    <= skid_rd;
                head_alu   <= skid_alu;
                skid_valid <= 1'b0;
            end else if (do_release) begin
                head_valid <= accept;
                if (accept) begin
                    head_wb   <= in_wb;
                    head_wreg <= in_wreg;
                    head_rd   <= in_rd;
                    head_alu  <= in_alu;
                end
            end else if (accept) begin
                if (head_valid) begin
                    skid_valid <= 1'b1;
                    skid_wb    <= in_wb;
                    skid_wreg  <= in_wreg;
                    skid_rd    <= in_rd;
                    skid_alu   <= in_alu;
                end else begin
                    head_valid <= 1'b1;
                    head_wb    <= in_wb;
                    head_wreg  <= in_wreg;
                    head_rd    <= in_rd;
                    head_alu   <= in_alu;
                end
            end
        end
    end

    // A bubble must never write back, so wb is gated; the data fields simply hold
    assign out_valid = head_valid;
    assign out_wb    = head_valid ? head_wb : '0;
    assign out_wreg  = head_wreg;
    assign out_rd    = head_rd;
    assign out_alu   = head_alu;
    assign occupancy = {1'b0, head_valid} + {1'b0, skid_valid};

`ifdef PIPE_STAGE_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic inc);
        return (inc && value != 32'hFFFF_FFFF) ? value + 32'd1 : value;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles  <= '0;
            bubble_cycles <= '0;
        end else if (en_reg) begin
            if (flush) begin
                stall_cycles  <= '0;
                bubble_cycles <= '0;
            end else begin
                stall_cycles  <= sat_inc(stall_cycles, head_valid & ~out_ready);
                bubble_cycles <= sat_inc(bubble_cycles, ~head_valid);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed scenarios followed by randomized traffic.
module tb_pipe_stage_skid;

    typedef struct packed {
        logic [1:0]  wb;
        logic [4:0]  wreg;
        logic [31:0] rd;
        logic [31:0] alu;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, en, fl, iv, ordy;
    ent_t        din;
    logic        in_ready, out_valid;
    logic [1:0]  out_wb, occupancy;
    logic [4:0]  out_wreg;
    logic [31:0] out_rd, out_alu;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cycles, bubble_cycles;
    int unsigned m_stall, m_bubble;
`endif

    int   vectors = 0;
    int   miscompares = 0;
    ent_t q[$];
    ent_t last;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(32), .WB_W(2), .REG_W(5)) dut (
        .clk(clk), .rst(rst), .en_reg(en), .flush(fl),
        .in_valid(iv), .in_ready(in_ready),
        .in_wb(din.wb), .in_wreg(din.wreg), .in_rd(din.rd), .in_alu(din.alu),
        .out_valid(out_valid), .out_ready(ordy),
        .out_wb(out_wb), .out_wreg(out_wreg), .out_rd(out_rd), .out_alu(out_alu),
        .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
`endif
    );

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t rnd_ent();
        ent_t e;
        e.wb   = 2'($urandom);
        e.wreg = 5'($urandom);
        e.rd   = $urandom;
        e.alu  = $urandom;
        return e;
    endfunction

    function automatic ent_t mk(input logic [31:0] alu);
        ent_t e;
        e.wb   = 2'b11;
        e.wreg = alu[4:0];
        e.rd   = ~alu;
        e.alu  = alu;
        return e;
    endfunction

    // Reference model: the stage is a FIFO of capacity 2 seen through its head
    always @(posedge clk) begin
        int  sz;
        logic acc, rel;
        if (rst) begin
            q.delete();
            last = '0;
`ifdef PIPE_STAGE_PERF_EN
            m_stall = 0; m_bubble = 0;
`endif
        end else if (en) begin
            if (fl) begin
                q.delete();
`ifdef PIPE_STAGE_PERF_EN
                m_stall = 0; m_bubble = 0;
`endif
            end else begin
                sz  = q.size();
`ifdef PIPE_STAGE_PERF_EN
                if (sz > 0 && !ordy && m_stall != 32'hFFFF_FFFF) m_stall++;
                if (sz == 0 && m_bubble != 32'hFFFF_FFFF) m_bubble++;
`endif
                acc = iv && (sz < 2);
                rel = (sz > 0) && ordy;
                if (rel) void'(q.pop_front());
                if (acc) q.push_back(din);
            end
        end
    end

    // Monitor: compare the presented head against the expected queue front
    always @(negedge clk) begin
        int sz;
        ent_t h;
        if (!rst) begin
            sz = q.size();
            h  = (sz > 0) ? q[0] : last;
            chk("out_valid", 72'(out_valid), 72'(sz > 0));
            chk("occupancy", 72'(occupancy), 72'(sz));
            chk("in_ready", 72'(in_ready), 72'(en && sz < 2));
            chk("out_wb", 72'(out_wb), 72'((sz > 0) ? h.wb : 2'b00));
            chk("out_wreg", 72'(out_wreg), 72'(h.wreg));
            chk("out_rd", 72'(out_rd), 72'(h.rd));
            chk("out_alu", 72'(out_alu), 72'(h.alu));
`ifdef PIPE_STAGE_PERF_EN
            chk("stall_cycles", 72'(stall_cycles), 72'(m_stall));
            chk("bubble_cycles", 72'(bubble_cycles), 72'(m_bubble));
`endif
            if (sz > 0) last = q[0];
        end
    end

    // Apply one cycle of stimulus; returns just after the clock edge that consumed it
    task automatic drive(input logic v, input ent_t e, input logic o, input logic en_i, input logic f);
        iv = v; din = e; ordy = o; en = en_i; fl = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; fl = 1'b0; iv = 1'b0; ordy = 1'b0; din = '0;
        @(posedge clk); #1;
        drive(0, '0, 0, 1, 0);
        chk("rst_out_valid", 72'(out_valid), 72'(0));
        chk("rst_occupancy", 72'(occupancy), 72'(0));
        chk("rst_in_ready", 72'(in_ready), 72'(0));
        chk("rst_out_alu", 72'(out_alu), 72'(0));
        rst = 1'b0;
        drive(0, '0, 1, 1, 0);
        chk("post_rst_in_ready", 72'(in_ready), 72'(1));

        // Streaming
        for (int k = 1; k <= 3; k++) begin
            drive(1, mk(32'(k)), 1, 1, 0);
            chk("stream_alu", 72'(out_alu), 72'(k));
            chk("stream_occ", 72'(occupancy), 72'(1));
            chk("stream_in_ready", 72'(in_ready), 72'(1));
        end
        drive(0, '0, 1, 1, 0);

        // Backpressure
        drive(1, mk(32'hA), 0, 1, 0);
        drive(1, mk(32'hB), 0, 1, 0);
        chk("bp_occ", 72'(occupancy), 72'(2));
        chk("bp_in_ready", 72'(in_ready), 72'(0));
        chk("bp_alu", 72'(out_alu), 72'(32'hA));

        // Freeze
        for (int k = 0; k < 5; k++) begin
            drive(1, mk(32'hF0), 1, 0, 0);
            chk("frz_occ", 72'(occupancy), 72'(2));
            chk("frz_alu", 72'(out_alu), 72'(32'hA));
            chk("frz_in_ready", 72'(in_ready), 72'(0));
        end
        drive(0, '0, 1, 1, 0);
        chk("drain_a_then_b", 72'(out_alu), 72'(32'hB));
        drive(0, '0, 1, 1, 0);
        chk("drain_empty_valid", 72'(out_valid), 72'(0));
        chk("drain_empty_wb", 72'(out_wb), 72'(0));
        chk("drain_hold_alu", 72'(out_alu), 72'(32'hB));

        // Flush
        drive(1, mk(32'hC), 0, 1, 0);
        drive(1, mk(32'hD), 0, 1, 0);
        chk("pre_flush_occ", 72'(occupancy), 72'(2));
        drive(1, mk(32'hE), 0, 1, 1);
        chk("flush_valid", 72'(out_valid), 72'(0));
        chk("flush_wb", 72'(out_wb), 72'(0));
        chk("flush_occ", 72'(occupancy), 72'(0));
        drive(0, '0, 1, 1, 0);
        chk("flushed_never_seen", 72'(out_valid), 72'(0));

        // Asynchronous reset between edges
        drive(1, mk(32'h11), 0, 1, 0);
        drive(1, mk(32'h22), 0, 1, 0);
        chk("pre_arst_occ", 72'(occupancy), 72'(2));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 72'(out_valid), 72'(0));
        chk("arst_occ", 72'(occupancy), 72'(0));
        chk("arst_alu", 72'(out_alu), 72'(0));
        chk("arst_rd", 72'(out_rd), 72'(0));
        chk("arst_wreg", 72'(out_wreg), 72'(0));
        chk("arst_in_ready", 72'(in_ready), 72'(0));
        drive(0, '0, 1, 1, 0);
        rst = 1'b0;
        drive(0, '0, 1, 1, 0);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            rst = (($urandom % 150) == 0);
            drive(1'($urandom), rnd_ent(), 1'($urandom), ($urandom % 6) != 0, ($urandom % 40) == 0);
        end
        rst = 1'b0;
        drive(0, '0, 1, 1, 0);

`ifdef PIPE_STAGE_PERF_EN
        drive(0, '0, 1, 1, 1);
        drive(1, mk(32'h33), 0, 1, 0);
        for (int k = 0; k < 4; k++) drive(0, '0, 0, 1, 0);
        drive(0, '0, 1, 1, 0);
        for (int k = 0; k < 2; k++) drive(0, '0, 1, 1, 0);
        chk("perf_stall", 72'(stall_cycles), 72'(4));
        chk("perf_bubble", 72'(bubble_cycles), 72'(3));
        drive(0, '0, 1, 1, 1);
        chk("perf_stall_clr", 72'(stall_cycles), 72'(0));
        chk("perf_bubble_clr", 72'(bubble_cycles), 72'(0));
`endif

        drive(0, '0, 1, 1, 0);
        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
